// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle (tdata/tvalid/tready/tlast) shared by both sides of the packet FIFO.
// A beat transfers on a rising clk edge where tvalid & tready; the source holds tdata/tlast until then.
interface axis_pkt_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: releases a packet only once its tlast is stored,
// falling back to cut-through when a packet fills the whole buffer without a tlast.
module axis_pkt_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  axis_pkt_fifo_if.slave      s_axis,
  axis_pkt_fifo_if.master     m_axis,
  output logic [ADDR_WIDTH:0] fill_level,
  output logic [ADDR_WIDTH:0] pkt_count,
  output logic                cut_through
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_valid;

  logic                  push;
  logic                  pop;
  logic                  release_ok;
  logic [DATA_WIDTH:0]   head;
  logic                  push_last;
  logic                  pop_last;

  // Pointer difference is the occupancy; the extra MSB separates full from empty.
  assign fill_level = wr_ptr - rd_ptr;

  // Ready is based on the registered occupancy only, so a full FIFO stays closed for the pop cycle.
  assign s_axis.tready = reset && (fill_level != FULL_COUNT);

  assign push       = s_axis.tvalid && s_axis.tready;
  assign release_ok = (pkt_count != '0) || cut_through;
  assign pop        = (!out_valid || m_axis.tready) && (fill_level != '0) && release_ok;
  assign head       = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign push_last  = push && s_axis.tlast;
  assign pop_last   = pop && head[DATA_WIDTH];

  assign m_axis.tdata  = out_data;
  assign m_axis.tlast  = out_last;
  assign m_axis.tvalid = out_valid;

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pkt_count   <= '0;
      cut_through <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        out_data  <= head[DATA_WIDTH-1:0];
        out_last  <= head[DATA_WIDTH];
        out_valid <= 1'b1;
      end else if (out_valid && m_axis.tready) begin
        out_valid <= 1'b0;
      end

      case ({push_last, pop_last})
        2'b10:   pkt_count <= pkt_count + PTR_ONE;
        2'b01:   pkt_count <= pkt_count - PTR_ONE;
        default: pkt_count <= pkt_count;
      endcase

      // Releasing the oversize packet's tlast ends the fallback, even if it would re-arm now.
      if (pop_last) begin
        cut_through <= 1'b0;
      end else if ((fill_level == FULL_COUNT) && (pkt_count == '0)) begin
        cut_through <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: scenario tasks plus a negedge scoreboard on the egress port.
module tb_axis_pkt_fifo;

  localparam int DW = 32;

  logic       clk;
  logic       reset;
  logic [4:0] fill_level;
  logic [4:0] pkt_count;
  logic       cut_through;

  axis_pkt_fifo_if #(.DATA_WIDTH(DW)) s_if ();
  axis_pkt_fifo_if #(.DATA_WIDTH(DW)) m_if ();

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .fill_level  (fill_level),
    .pkt_count   (pkt_count),
    .cut_through (cut_through)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset     = 1'b0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, exp_q size %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // scoreboard: egress beats compared against expected queue, stall stability checked
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data || m_if.tlast !== prev_last) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   m_if.tvalid, m_if.tdata, m_if.tlast, prev_data, prev_last);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h last=%b, need no beat", m_if.tdata, m_if.tlast);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({m_if.tlast, m_if.tdata} !== e) begin
            errors++;
            $display("FAIL egress_beat: got last=%b data=%h, need last=%b data=%h",
                     m_if.tlast, m_if.tdata, e[DW], e[DW-1:0]);
          end
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
    end
  end

  // driver: offer one beat, wait (bounded) for acceptance, return 1 time unit after the edge
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic track);
    logic ok;
    ok = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (s_if.tready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ingress_timeout: beat %h not accepted, tready=%b", d, s_if.tready);
    end else if (track) begin
      exp_q.push_back({last, d});
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d beats missing", name, exp_q.size());
    end
    checks++;
    if (m_if.tvalid !== 1'b0 || fill_level !== 5'd0 || pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL %s_empty: got valid=%b fill=%0d pkts=%0d, need 0 0 0",
               name, m_if.tvalid, fill_level, pkt_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || m_if.tlast !== 1'b0 ||
        fill_level !== 5'd0 || pkt_count !== 5'd0 || cut_through !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h last=%b fill=%0d pkts=%0d ct=%b, need all 0",
               s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, fill_level, pkt_count, cut_through);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h10 + i, i == 3, 1'b1);
      checks++;
      if (m_if.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL single_early_valid: beat %0d got tvalid=%b, need 0", i, m_if.tvalid);
      end
    end
    checks++;
    if (pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL single_pkt_count: got %0d, need 1", pkt_count);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h10 + i) begin
        errors++;
        $display("FAIL single_burst: cycle %0d got vld=%b data=%h, need vld=1 data=%h",
                 i, m_if.tvalid, m_if.tdata, 32'h10 + i);
      end
    end
    drain("single");
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    pat = 4'b1001;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(32'hA0 + i, i == 7, 1'b1);
      end
      begin
        for (int i = 0; i < 48; i++) begin
          m_if.tready = pat[3 - (i % 4)];
          @(posedge clk);
          #1;
        end
      end
    join
    m_if.tready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_oversize();
    logic seen18;
    logic done;
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) send_beat(i, 1'b0, 1'b1);
    checks++;
    if (fill_level !== 5'd16 || s_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL oversize_full: got fill=%0d rdy=%b, need 16 0", fill_level, s_if.tready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cut_through !== 1'b1 || fill_level !== 5'd16 || s_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL oversize_cut_set: got ct=%b fill=%0d rdy=%b, need 1 16 0",
               cut_through, fill_level, s_if.tready);
    end
    seen18 = 1'b0;
    done   = 1'b0;
    fork
      begin
        for (int i = 16; i < 20; i++) send_beat(i, i == 19, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        m_if.tready = 1'b1;
      end
      begin
        for (int i = 0; i < 300 && !done; i++) begin
          @(posedge clk);
          #1;
          if (m_if.tvalid && m_if.tdata == 32'd18 && !seen18) begin
            seen18 = 1'b1;
            checks++;
            if (cut_through !== 1'b1) begin
              errors++;
              $display("FAIL oversize_cut_hold: got ct=%b at beat 18, need 1", cut_through);
            end
          end
          if (m_if.tvalid && m_if.tdata == 32'd19) begin
            done = 1'b1;
            checks++;
            if (cut_through !== 1'b0) begin
              errors++;
              $display("FAIL oversize_cut_clear: got ct=%b at beat 19, need 0", cut_through);
            end
          end
        end
        checks++;
        if (!done || !seen18) begin
          errors++;
          $display("FAIL oversize_tail_timeout: seen18=%b seen19=%b, need 1 1", seen18, done);
        end
      end
    join
    drain("oversize");
  endtask

  task automatic test_back_to_back();
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(32'h30 + i, i == 2, 1'b1);
    for (int i = 0; i < 5; i++) send_beat(32'h40 + i, i == 4, 1'b1);
    // The head beat of the first packet already moved into the empty output register.
    checks++;
    if (pkt_count !== 5'd2 || fill_level !== 5'd7 || m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h30) begin
      errors++;
      $display("FAIL b2b_levels: got pkts=%0d fill=%0d vld=%b data=%h, need 2 7 1 30",
               pkt_count, fill_level, m_if.tvalid, m_if.tdata);
    end
    m_if.tready = 1'b1;
    drain("b2b");
  endtask

  task automatic test_simultaneous();
    m_if.tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(32'h60 + i, i == 7, 1'b1);
    @(posedge clk);
    #1;
    send_beat(32'h68, 1'b1, 1'b1);
    checks++;
    if (fill_level !== 5'd8 || m_if.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup: got fill=%0d vld=%b, need 8 1", fill_level, m_if.tvalid);
    end
    m_if.tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(32'h70 + i, 1'b1, 1'b1);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          #1;
          checks++;
          if (fill_level !== 5'd8) begin
            errors++;
            $display("FAIL simul_fill: cycle %0d got fill=%0d, need 8", i, fill_level);
          end
        end
      end
    join
    drain("simul");
  endtask

  task automatic test_reset_mid();
    m_if.tready = 1'b1;
    send_beat(32'h50, 1'b0, 1'b0);
    send_beat(32'h51, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || m_if.tlast !== 1'b0 ||
        fill_level !== 5'd0 || pkt_count !== 5'd0 || cut_through !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got rdy=%b vld=%b data=%h last=%b fill=%0d pkts=%0d ct=%b, need all 0",
               s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, fill_level, pkt_count, cut_through);
    end
    @(negedge clk);
    checks++;
    if (s_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got %b during reset, need 0", s_if.tready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_beat(32'h55, 1'b0, 1'b1);
    send_beat(32'h56, 1'b1, 1'b1);
    drain("midreset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_oversize();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
